// File: rtl/operand_bank_loader.sv
// Operand store for the systolic engine: NUM_BANKS banks of wide lines, written and read
// one host word at a time, read by the engine a line at a time, plus a go/finish run sequencer.
module operand_bank_loader #(
  parameter int DATA_W    = 32,
  parameter int LINE_W    = 128,
  parameter int NUM_BANKS = 2,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = $clog2(DEPTH * (LINE_W / DATA_W)),
  parameter int LADDR_W   = $clog2(DEPTH),
  parameter int BSEL_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wready_q,
  input  logic [ADDR_W-1:0]  write_addr,
  input  logic [DATA_W-1:0]  hello_world_q,
  input  logic [BSEL_W-1:0]  bank_sel,
  input  logic               arvalid,
  input  logic [ADDR_W-1:0]  read_addr,
  output logic [DATA_W-1:0]  ram_data,
  output logic               rvalid,
  input  logic               go,
  output logic               eng_start,
  input  logic               eng_done,
  input  logic               eng_rd_en,
  input  logic [BSEL_W-1:0]  eng_bank,
  input  logic [LADDR_W-1:0] eng_addr,
  output logic [LINE_W-1:0]  eng_line,
  output logic               eng_line_valid,
  output logic               busy,
  output logic               finish,
  output logic               err,
  output logic [1:0]         dbg_state
);

  localparam int WORDS     = LINE_W / DATA_W;
  localparam int LANE_BITS = $clog2(WORDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Handshake: wready_q, arvalid, eng_rd_en and go are single-cycle strobes with no
  // back-pressure; every read strobe is answered exactly one cycle later by a one-cycle
  // valid pulse (rvalid / eng_line_valid), even when the access itself is rejected.

  logic [LINE_W-1:0] mem_q [NUM_BANKS][DEPTH];

  state_e              state_q;
  logic                eng_start_q;
  logic                busy_q;
  logic                finish_q;
  logic                err_q;
  logic [DATA_W-1:0]   ram_data_q;
  logic                rvalid_q;
  logic [LINE_W-1:0]   eng_line_q;
  logic                eng_line_valid_q;

  logic [LADDR_W-1:0]  wr_line;
  logic [LADDR_W-1:0]  rd_line;
  int                  wr_lane;
  int                  rd_lane;
  logic                host_bank_ok;
  logic                eng_bank_ok;
  logic                wr_locked;
  logic                wr_accept;
  logic                go_accept;
  logic                err_set;
  logic [DATA_W-1:0]   rd_word_d;
  logic [LINE_W-1:0]   eng_word_d;

  assign wr_line = LADDR_W'(write_addr >> LANE_BITS);
  assign rd_line = LADDR_W'(read_addr >> LANE_BITS);
  assign wr_lane = int'(write_addr) % WORDS;
  assign rd_lane = int'(read_addr) % WORDS;

  assign host_bank_ok = int'(bank_sel) < NUM_BANKS;
  assign eng_bank_ok  = int'(eng_bank) < NUM_BANKS;
  assign wr_locked    = (state_q == S_START) || (state_q == S_RUN);
  assign wr_accept    = wready_q && !wr_locked && host_bank_ok;
  assign go_accept    = go && (state_q == S_IDLE);
  assign err_set      = (wready_q && (wr_locked || !host_bank_ok))
                      || (arvalid && !host_bank_ok)
                      || (eng_rd_en && !eng_bank_ok);

  always_comb begin
    rd_word_d = '0;
    if (host_bank_ok) begin
      for (int k = 0; k < WORDS; k++) begin
        if (rd_lane == k) rd_word_d = mem_q[bank_sel][rd_line][k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    eng_word_d = '0;
    if (eng_bank_ok) eng_word_d = mem_q[eng_bank][eng_addr];
  end

  // Lane-granular write; reads sample the array before this edge's update, giving read-before-write.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int k = 0; k < WORDS; k++) begin
        if (wr_lane == k) mem_q[bank_sel][wr_line][k*DATA_W +: DATA_W] <= hello_world_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_data_q       <= '0;
      rvalid_q         <= 1'b0;
      eng_line_q       <= '0;
      eng_line_valid_q <= 1'b0;
    end else begin
      rvalid_q         <= arvalid;
      eng_line_valid_q <= eng_rd_en;
      if (arvalid)   ram_data_q <= rd_word_d;
      if (eng_rd_en) eng_line_q <= eng_word_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      eng_start_q <= 1'b0;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (err_set)        err_q <= 1'b1;
      else if (go_accept) err_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          finish_q <= 1'b0;
          if (go) begin
            state_q     <= S_START;
            eng_start_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        S_START: begin
          state_q     <= S_RUN;
          eng_start_q <= 1'b0;
        end
        S_RUN: begin
          if (eng_done) begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            finish_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q  <= S_IDLE;
          finish_q <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          eng_start_q <= 1'b0;
          busy_q      <= 1'b0;
          finish_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ram_data       = ram_data_q;
  assign rvalid         = rvalid_q;
  assign eng_line       = eng_line_q;
  assign eng_line_valid = eng_line_valid_q;
  assign eng_start      = eng_start_q;
  assign busy           = busy_q;
  assign finish         = finish_q;
  assign err            = err_q;
  assign dbg_state      = state_q;

endmodule

// File: doc/operand_bank_loader.md
# operand_bank_loader

Host-side operand store and run sequencer for the systolic matrix engine, generalising the fixed A/B load path to `NUM_BANKS` banks of parametrised width and depth. Host writes narrow words that are packed into wide memory lines; the host can read any word back; the engine reads whole lines through a separate port. A small FSM accepts `go`, pulses the engine start, waits for engine completion, and returns `finish`; host writes are locked out during a run.

## Interface
- `DATA_W`, 32: host word width.
- `LINE_W`, 128: memory line width; `LINE_W/DATA_W` = WORDS, a power of two ≥1.
- `NUM_BANKS`, 2: operand banks, ≥1 (bank 0 = A, bank 1 = B by convention).
- `DEPTH`, 16: lines per bank, a power of two.
- `ADDR_W`, log2(DEPTH*WORDS): host word address width.
- `LADDR_W`, log2(DEPTH): line address width.
- `BSEL_W`, max(1, ceil(log2(NUM_BANKS))): bank select width.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `wready_q` in 1: host write strobe.
- `write_addr` in ADDR_W: host word address.
- `hello_world_q` in DATA_W: host write data.
- `bank_sel` in BSEL_W: bank for host write and read.
- `arvalid` in 1: host read strobe.
- `read_addr` in ADDR_W: host read word address.
- `ram_data` out DATA_W: host read data.
- `rvalid` out 1: `ram_data` valid.
- `go` in 1: run request.
- `eng_start` out 1: one-cycle engine start pulse.
- `eng_done` in 1: engine completion.
- `eng_rd_en` in 1: engine line read.
- `eng_bank` in BSEL_W: engine read bank.
- `eng_addr` in LADDR_W: engine line address.
- `eng_line` out LINE_W: engine read data.
- `eng_line_valid` out 1: `eng_line` valid.
- `busy` out 1: high in START and RUN.
- `finish` out 1: one-cycle completion pulse.
- `err` out 1: sticky error flag.

## Operation
- Word mapping: line = `write_addr[ADDR_W-1:log2(WORDS)]`, lane = low log2(WORDS) bits; lane k occupies bits [k*DATA_W +: DATA_W]. Same mapping for `read_addr`.
- Host write, when `wready_q`=1, FSM in IDLE or DONE, and `bank_sel` < NUM_BANKS: writes only the addressed lane. Other lanes are unchanged; no read-modify-write is visible.
- Host write while `busy`: discarded, and `err` is set.
- Host access with `bank_sel` ≥ NUM_BANKS: discarded, and `err` is set. For a read, `rvalid` still pulses with `ram_data`=0.
- Host read is accepted in any state and is never blocked by the engine.
- Same-cycle host write and read to the same word: the read returns the old data (read-before-write).
- Engine read is accepted in any state. Out-of-range `eng_bank` returns all zeros and sets `err`.
- FSM states:
  - IDLE: `go`=1 → START, and `err` is cleared.
  - START: `eng_start`=1 for this one cycle → RUN.
  - RUN: `eng_done`=1 → DONE.
  - DONE: `finish`=1 for this one cycle → IDLE.
- `go` outside IDLE is ignored. `eng_done` outside RUN is ignored.
- `err` sets on any error event and clears only on an accepted `go` or on reset. Set has priority over clear in the same cycle.
- Reset, asynchronous, also mid-run: FSM returns to IDLE. `ram_data`, `rvalid`, `eng_start`, `eng_line`, `eng_line_valid`, `busy`, `finish` and `err` all go to 0. Bank contents are not reset.

## Timing
- Host write: data is visible to a read issued in the next cycle.
- Host read latency is 1: `arvalid` at edge n gives `rvalid`=1 and `ram_data` after edge n. `rvalid` is a single-cycle pulse per strobe, back-to-back capable. `ram_data` holds its value until the next read.
- Engine read latency is 1, fully pipelined, one line per cycle. An engine write-after-host-write to the same line sees the new data after one cycle.
- `go` at edge n gives `eng_start` and `busy` high after edge n.
- `eng_done` at edge m gives `finish`=1 and `busy`=0 after edge m, then IDLE one cycle later. A new `go` is accepted in DONE+1 (IDLE) at the earliest.
- Minimum `go` to `finish` is 3 cycles when `eng_done` arrives in the first RUN cycle.

## Test plan
- Packing, defaults: write bank 0 addrs 0..63 with data (i+1)%4, then read 0..63 → `ram_data` = (i+1)%4, `rvalid` one cycle after each `arvalid`. Engine read of bank 0 line 0 → `eng_line` = 128'h00000000_00000003_00000002_00000001.
- Lane isolation: write 0xAAAA_AAAA to addr 5 (line 1, lane 1), then 0x5555_5555 to addr 6 → line 1 = {lane3 old, 0x55555555, 0xAAAAAAAA, lane0 old}.
- Run handshake: `go` pulse, then `eng_done` after 10 cycles. Required: `eng_start` for exactly one cycle, `busy` for 11 cycles, `finish` for one cycle, a second `go` during RUN ignored.
- Lockout and error: `wready_q` to addr 0 during RUN → memory unchanged, `err`=1. `err` stays set until the next accepted `go`. `bank_sel`=2 with NUM_BANKS=2 sets `err` and returns 0.
- Collision: same-cycle write 0x1234 and read of addr 9 holding 0x77 → `ram_data`=0x77; a read next cycle gives 0x1234.
- Reset mid-run: drive `reset` low asynchronously in RUN → all outputs 0 immediately, state IDLE. After reset release, data previously written is still readable.
